vga_stream_timing: RTL



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_raster_cnt.sv | 74 +++++++
 rtl/vga_stream_timing.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, FSM state type and raster length helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

   // Default raster: 800x480 panel timing
   localparam int unsigned VGA_HDISP  = 800;
   localparam int unsigned VGA_VDISP  = 480;
   localparam int unsigned VGA_HFP    = 40;
   localparam int unsigned VGA_HPULSE = 48;
   localparam int unsigned VGA_HBP    = 40;
   localparam int unsigned VGA_VFP    = 13;
   localparam int unsigned VGA_VPULSE = 3;
   localparam int unsigned VGA_VBP    = 29;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,   // hunting for a start-of-frame beat, discarding others
      ARMED = 2'd1,   // sof beat held at the head, waiting for raster frame end
      RUN   = 2'd2    // stream locked to the raster
   } vga_state_t;

   // Total length of one axis (line in pixels, frame in lines)
   function automatic int unsigned vga_total(input int unsigned disp,
                                             input int unsigned front,
                                             input int unsigned pulse,
                                             input int unsigned back);
      return disp + front + pulse + back;
   endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Raster position counters with active-area and sync-level decode.
// Latency: decode outputs are combinational from the px/py registers.
// Backpressure: none; free-running while en is high, held at 0 while en is low.
//
// Ports: pixel_clk / pixel_rst_n (async, active-low) / en,
//        px, py        current raster position
//        active        px < HDISP && py < VDISP
//        frame_first   position (0,0)
//        frame_last    position (XLEN-1, YLEN-1)
//        hs_lvl/vs_lvl sync levels for the current position, polarity applied
module vga_raster_cnt
   import vga_pkg::*;
#(
   parameter int unsigned HDISP  = VGA_HDISP,
   parameter int unsigned VDISP  = VGA_VDISP,
   parameter int unsigned HFP    = VGA_HFP,
   parameter int unsigned HPULSE = VGA_HPULSE,
   parameter int unsigned HBP    = VGA_HBP,
   parameter int unsigned VFP    = VGA_VFP,
   parameter int unsigned VPULSE = VGA_VPULSE,
   parameter int unsigned VBP    = VGA_VBP,
   parameter bit          HS_POL = 1'b0,
   parameter bit          VS_POL = 1'b0,
   localparam int unsigned XLEN  = vga_total(HDISP, HFP, HPULSE, HBP),
   localparam int unsigned YLEN  = vga_total(VDISP, VFP, VPULSE, VBP),
   localparam int unsigned XCW   = $clog2(XLEN),
   localparam int unsigned YCW   = $clog2(YLEN)
) (
   input  logic           pixel_clk,
   input  logic           pixel_rst_n,
   input  logic           en,
   output logic [XCW-1:0] px,
   output logic [YCW-1:0] py,
   output logic           active,
   output logic           frame_first,
   output logic           frame_last,
   output logic           hs_lvl,
   output logic           vs_lvl
);

   localparam logic [XCW-1:0] X_LAST = XCW'(XLEN - 1);
   localparam logic [YCW-1:0] Y_LAST = YCW'(YLEN - 1);
   localparam logic [XCW-1:0] H_ACT  = XCW'(HDISP);
   localparam logic [YCW-1:0] V_ACT  = YCW'(VDISP);
   localparam logic [XCW-1:0] HS_BEG = XCW'(HDISP + HFP);
   localparam logic [XCW-1:0] HS_END = XCW'(HDISP + HFP + HPULSE);
   localparam logic [YCW-1:0] VS_BEG = YCW'(VDISP + VFP);
   localparam logic [YCW-1:0] VS_END = YCW'(VDISP + VFP + VPULSE);

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         px <= '0;
         py <= '0;
      end else if (!en) begin
         px <= '0;
         py <= '0;
      end else if (px == X_LAST) begin
         px <= '0;
         py <= (py == Y_LAST) ? '0 : py + 1'b1;
      end else begin
         px <= px + 1'b1;
      end
   end

   always_comb begin
      active      = (px < H_ACT) && (py < V_ACT);
      frame_first = (px == '0) && (py == '0);
      frame_last  = (px == X_LAST) && (py == Y_LAST);
      // vs is decoded from the line number only, so it spans whole lines
      hs_lvl      = (px >= HS_BEG && px < HS_END) ? HS_POL : !HS_POL;
      vs_lvl      = (py >= VS_BEG && py < VS_END) ? VS_POL : !VS_POL;
   end

endmodule

// File: rtl/vga_stream_timing.sv
// VGA timing generator that locks a valid/ready pixel stream (with sof) to the raster.
// Latency: hs/vs/blank/rgb/x/y/locked/underflow/sof_err reflect raster position n at cycle n+1.
// Backpressure: pix_ready is combinational; beats are only taken in active pixels while locked,
//               or discarded while hunting for sof; never taken in reset or with en low.
//
// Ports: pixel_clk, pixel_rst_n (async, active-low), en (raster enable)
//        pix_data/pix_sof/pix_valid/pix_ready  pixel stream sink
//        hs, vs, blank (1 = active area), rgb, x, y   registered video outputs
//        locked (stream locked), underflow, sof_err (one-cycle error pulses)
module vga_stream_timing
   import vga_pkg::*;
#(
   parameter int unsigned       HDISP    = VGA_HDISP,
   parameter int unsigned       VDISP    = VGA_VDISP,
   parameter int unsigned       HFP      = VGA_HFP,
   parameter int unsigned       HPULSE   = VGA_HPULSE,
   parameter int unsigned       HBP      = VGA_HBP,
   parameter int unsigned       VFP      = VGA_VFP,
   parameter int unsigned       VPULSE   = VGA_VPULSE,
   parameter int unsigned       VBP      = VGA_VBP,
   parameter bit                HS_POL   = 1'b0,
   parameter bit                VS_POL   = 1'b0,
   parameter int unsigned       RGB_W    = 24,
   parameter logic [RGB_W-1:0]  FILL_RGB = RGB_W'(24'hFF00FF),
   localparam int unsigned      XW       = $clog2(HDISP),
   localparam int unsigned      YW       = $clog2(VDISP)
) (
   input  logic             pixel_clk,
   input  logic             pixel_rst_n,
   input  logic             en,
   input  logic [RGB_W-1:0] pix_data,
   input  logic             pix_sof,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             hs,
   output logic             vs,
   output logic             blank,
   output logic [RGB_W-1:0] rgb,
   output logic [XW-1:0]    x,
   output logic [YW-1:0]    y,
   output logic             locked,
   output logic             underflow,
   output logic             sof_err
);

   localparam int unsigned XCW = $clog2(vga_total(HDISP, HFP, HPULSE, HBP));
   localparam int unsigned YCW = $clog2(vga_total(VDISP, VFP, VPULSE, VBP));

   logic [XCW-1:0] px;
   logic [YCW-1:0] py;
   logic           active;
   logic           frame_first;
   logic           frame_last;
   logic           hs_lvl;
   logic           vs_lvl;

   vga_state_t       state;
   vga_state_t       state_nx;
   logic             ready_raw;
   logic             take;
   logic             uf_nx;
   logic             se_nx;
   logic [RGB_W-1:0] rgb_nx;

   vga_raster_cnt #(
      .HDISP  (HDISP),
      .VDISP  (VDISP),
      .HFP    (HFP),
      .HPULSE (HPULSE),
      .HBP    (HBP),
      .VFP    (VFP),
      .VPULSE (VPULSE),
      .VBP    (VBP),
      .HS_POL (HS_POL),
      .VS_POL (VS_POL)
   ) u_raster (
      .pixel_clk   (pixel_clk),
      .pixel_rst_n (pixel_rst_n),
      .en          (en),
      .px          (px),
      .py          (py),
      .active      (active),
      .frame_first (frame_first),
      .frame_last  (frame_last),
      .hs_lvl      (hs_lvl),
      .vs_lvl      (vs_lvl)
   );

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         state <= SEEK;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      ready_raw = 1'b0;
      take      = 1'b0;
      uf_nx     = 1'b0;
      se_nx     = 1'b0;
      if (!en) begin
         state_nx = SEEK;
      end else begin
         case (state)
            SEEK: begin
               // Non-sof beats are drained; a sof beat is left at the head for ARMED
               ready_raw = !pix_sof;
               if (pix_valid && pix_sof) begin
                  state_nx = ARMED;
               end
            end
            ARMED: begin
               if (frame_last) begin
                  state_nx = RUN;
               end
            end
            RUN: begin
               if (active) begin
                  // Only accept a beat whose sof flag matches the raster position,
                  // so a misplaced beat stays at the head for the next frame
                  ready_raw = (pix_sof == frame_first);
                  if (!pix_valid) begin
                     uf_nx    = 1'b1;
                     state_nx = SEEK;
                  end else if (pix_sof != frame_first) begin
                     se_nx    = 1'b1;
                     state_nx = frame_first ? SEEK : ARMED;
                  end else begin
                     take = 1'b1;
                  end
               end
            end
            default: state_nx = SEEK;
         endcase
      end
      pix_ready = ready_raw && pixel_rst_n;
   end

   always_comb begin
      rgb_nx = '0;
      if (active) begin
         rgb_nx = take ? pix_data : FILL_RGB;
      end
   end

   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         hs        <= !HS_POL;
         vs        <= !VS_POL;
         blank     <= 1'b0;
         rgb       <= '0;
         x         <= '0;
         y         <= '0;
         locked    <= 1'b0;
         underflow <= 1'b0;
         sof_err   <= 1'b0;
      end else if (!en) begin
         hs        <= !HS_POL;
         vs        <= !VS_POL;
         blank     <= 1'b0;
         rgb       <= '0;
         x         <= '0;
         y         <= '0;
         locked    <= 1'b0;
         underflow <= 1'b0;
         sof_err   <= 1'b0;
      end else begin
         hs        <= hs_lvl;
         vs        <= vs_lvl;
         blank     <= active;
         rgb       <= rgb_nx;
         x         <= px[XW-1:0];
         y         <= py[YW-1:0];
         // Registered so locked lines up with the pixel it describes
         locked    <= (state == RUN);
         underflow <= uf_nx;
         sof_err   <= se_nx;
      end
   end

endmodule
